dmem_arbiter: RTL and testbench

Arbiter and sequencer for the single-port data memory, shared between the load unit and the store unit. It grants one requester per transaction with round-robin priority on conflict. It drives the memory address, read/write mode, write data and byte strobes, and returns read data to the load unit after the memory's one-cycle read latency. Store byte-lane placement and alignment checking are done here, so the memory sees only aligned word-lane writes.

---
 rtl/dmem_arbiter_pkg.sv | 8 +
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter_store_lane_align.sv | 16 +
 rtl/dmem_arbiter.sv | 53 +++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared types for the data-memory arbiter (store sizes, FSM states, grant owner)
package dmem_arbiter_pkg;
   localparam logic [1:0] ST_SB = 2'b00;
   localparam logic [1:0] ST_SH = 2'b01;
   localparam logic [1:0] ST_SW = 2'b10;
   typedef enum logic {IDLE, RD_WAIT} arb_state_t;
   typedef enum logic {LOAD, STORE} grant_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundle of load/store requester handshakes and the single-port memory bus
//   ld_req/ld_addr -> ld_done/ld_rdata        load handshake
//   st_req/st_addr/st_size/st_data -> st_done/st_err   store handshake
//   dmem_stall                                 a request is waiting this cycle
//   mem_rw_mode/mem_addr/mem_wdata/mem_wstrb -> memory, mem_data <- memory
//   slave modport: arbiter side; master modport: requesters plus memory
interface dmem_arbiter_if #(parameter int ADDR_W = 32);
   logic              ld_req;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_done;
   logic [31:0]       ld_rdata;
   logic              st_req;
   logic [ADDR_W-1:0] st_addr;
   logic [1:0]        st_size;
   logic [31:0]       st_data;
   logic              st_done;
   logic              st_err;
   logic              dmem_stall;
   logic              mem_rw_mode;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_data;
   modport slave (
      input  ld_req, ld_addr, st_req, st_addr, st_size, st_data, mem_data,
      output ld_done, ld_rdata, st_done, st_err, dmem_stall,
             mem_rw_mode, mem_addr, mem_wdata, mem_wstrb
   );
   modport master (
      output ld_req, ld_addr, st_req, st_addr, st_size, st_data, mem_data,
      input  ld_done, ld_rdata, st_done, st_err, dmem_stall,
             mem_rw_mode, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/dmem_arbiter_store_lane_align.sv
// dmem_arbiter_store_lane_align: places store data on byte lanes and flags misaligned/reserved stores
//   i_size, i_off (byte offset), i_data -> o_wstrb, o_wdata, o_misaligned
module dmem_arbiter_store_lane_align
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_data,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata,
   output logic        o_misaligned
);
   assign o_misaligned = (i_size == ST_SH && i_off[0]) || (i_size == ST_SW && i_off != 2'b00) || i_size == 2'b11;
   assign o_wstrb = o_misaligned ? 4'b0000 : i_size == ST_SB ? 4'b0001 << i_off : i_size == ST_SH ? 4'b0011 << i_off : 4'hF;
   assign o_wdata = i_size == ST_SB ? {4{i_data[7:0]}} : i_size == ST_SH ? {2{i_data[15:0]}} : i_data;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin load/store arbiter and sequencer for the single-port data memory
//   i_clk, i_rst (async active-low), bus (dmem_arbiter_if.slave: requester handshakes + memory bus)
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic           i_clk,
   input  logic           i_rst,
   dmem_arbiter_if.slave  bus
);
   arb_state_t  r_state, w_next;
   grant_t      r_last, w_last_next;
   logic [31:0] r_rdata;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;
   logic        w_mis, w_idle, w_grant_ld, w_grant_st;
   dmem_arbiter_store_lane_align u_align (
      .i_size       (bus.st_size),
      .i_off        (bus.st_addr[1:0]),
      .i_data       (bus.st_data),
      .o_wstrb      (w_wstrb),
      .o_wdata      (w_wdata),
      .o_misaligned (w_mis)
   );
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
         r_state <= IDLE;
         r_last  <= STORE;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         r_last  <= w_last_next;
         if (r_state == RD_WAIT) r_rdata <= bus.mem_data;
      end
   // Grants are suppressed while reset is held so the bus shows idle values immediately.
   always_comb begin
      w_idle          = i_rst && r_state == IDLE;
      w_grant_ld      = w_idle && bus.ld_req && (!bus.st_req || r_last == STORE);
      w_grant_st      = w_idle && bus.st_req && (!bus.ld_req || r_last == LOAD);
      w_next          = w_grant_ld ? RD_WAIT : IDLE;
      w_last_next     = w_grant_ld ? LOAD : w_grant_st ? STORE : r_last;
      bus.ld_done     = i_rst && r_state == RD_WAIT;
      bus.ld_rdata    = bus.ld_done ? bus.mem_data : r_rdata;
      bus.st_done     = w_grant_st;
      bus.st_err      = w_grant_st && w_mis;
      bus.dmem_stall  = (bus.ld_req && !bus.ld_done) || (bus.st_req && !bus.st_done);
      bus.mem_rw_mode = !(w_grant_st && !w_mis);
      bus.mem_addr    = w_grant_ld ? bus.ld_addr & ~ADDR_W'(3) : w_grant_st ? bus.st_addr & ~ADDR_W'(3) : '0;
      bus.mem_wstrb   = w_grant_st ? w_wstrb : 4'b0000;
      bus.mem_wdata   = w_grant_st ? w_wdata : '0;
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a small memory model
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;
   logic        i_clk;
   logic        i_rst;
   int          checks;
   int          failures;
   logic [31:0] mem [0:255];
   logic        pend_ld, pend_st;
   dmem_arbiter_if #(.ADDR_W(32)) bus ();
   dmem_arbiter #(.ADDR_W(32)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus.slave)
   );
   wire [4:0] flags = {bus.ld_done, bus.st_done, bus.st_err, bus.dmem_stall, bus.mem_rw_mode};
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;
   // single-port memory: byte-strobed writes, one-cycle read latency
   always @(posedge i_clk) begin
      if (bus.mem_rw_mode === 1'b0)
         for (int b = 0; b < 4; b++)
            if (bus.mem_wstrb[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_data <= mem[bus.mem_addr[9:2]];
   end
   // requests must stay high until their done pulse
   always @(negedge i_clk) begin
      #3;
      if (i_rst === 1'b1 && pend_ld === 1'b1)
         assert (bus.ld_req) else begin failures++; $display("FAIL protocol_ld_drop ld_req=%b required 1", bus.ld_req); end
      if (i_rst === 1'b1 && pend_st === 1'b1)
         assert (bus.st_req) else begin failures++; $display("FAIL protocol_st_drop st_req=%b required 1", bus.st_req); end
      pend_ld = i_rst && bus.ld_req && !bus.ld_done;
      pend_st = i_rst && bus.st_req && !bus.st_done;
   end
   task automatic test_reset();
      i_rst = 1'b0;
      repeat (2) @(negedge i_clk);
      #1;
      checks++;
      if (flags !== 5'b00001 || bus.mem_addr !== 32'h0 || bus.mem_wstrb !== 4'h0 || bus.ld_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset flags=%b addr=%h wstrb=%b rdata=%h required 00001 0 0 0", flags, bus.mem_addr, bus.mem_wstrb, bus.ld_rdata);
      end
      i_rst = 1'b1;
      @(negedge i_clk);
      #1;
      checks++;
      if (flags !== 5'b00001 || bus.mem_addr !== 32'h0) begin
         failures++;
         $display("FAIL idle flags=%b addr=%h required 00001 0", flags, bus.mem_addr);
      end
   endtask
   task automatic test_lone_load();
      @(negedge i_clk);
      bus.ld_req = 1'b1; bus.ld_addr = 32'h102;
      #1;
      checks++;
      if (flags !== 5'b00011 || bus.mem_addr !== 32'h100) begin
         failures++;
         $display("FAIL load_grant flags=%b addr=%h required 00011 100", flags, bus.mem_addr);
      end
      @(negedge i_clk);
      #1;
      checks++;
      if (flags !== 5'b10001 || bus.ld_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL load_done flags=%b rdata=%h required 10001 deadbeef", flags, bus.ld_rdata);
      end
      @(negedge i_clk);
      bus.ld_req = 1'b0;
      #1;
      checks++;
      if (flags !== 5'b00001 || bus.ld_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL load_hold flags=%b rdata=%h required 00001 deadbeef", flags, bus.ld_rdata);
      end
   endtask
   task automatic test_lone_sb();
      @(negedge i_clk);
      bus.st_req = 1'b1; bus.st_addr = 32'h103; bus.st_size = ST_SB; bus.st_data = 32'h000000AB;
      #1;
      checks++;
      if (flags !== 5'b01000 || bus.mem_addr !== 32'h100 || bus.mem_wstrb !== 4'b1000 || bus.mem_wdata !== 32'hABABABAB) begin
         failures++;
         $display("FAIL store_sb flags=%b addr=%h wstrb=%b wdata=%h required 01000 100 1000 abababab", flags, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
      end
      @(negedge i_clk);
      bus.st_req = 1'b0;
      #1;
      checks++;
      if (mem[64] !== 32'hABADBEEF || flags !== 5'b00001) begin
         failures++;
         $display("FAIL store_sb_mem mem=%h flags=%b required abadbeef 00001", mem[64], flags);
      end
   endtask
   task automatic test_tie();
      @(negedge i_clk);
      bus.ld_req = 1'b1; bus.ld_addr = 32'h100;
      bus.st_req = 1'b1; bus.st_addr = 32'h200; bus.st_size = ST_SW; bus.st_data = 32'h12345678;
      #1;
      checks++;
      if (flags !== 5'b00011 || bus.mem_addr !== 32'h100) begin
         failures++;
         $display("FAIL tie_load_first flags=%b addr=%h required 00011 100", flags, bus.mem_addr);
      end
      @(negedge i_clk);
      #1;
      checks++;
      if (flags !== 5'b10011 || bus.ld_rdata !== 32'hABADBEEF) begin
         failures++;
         $display("FAIL tie_load_done flags=%b rdata=%h required 10011 abadbeef", flags, bus.ld_rdata);
      end
      @(negedge i_clk);
      #1;
      checks++;
      if (flags !== 5'b01010 || bus.mem_addr !== 32'h200 || bus.mem_wstrb !== 4'hF || bus.mem_wdata !== 32'h12345678) begin
         failures++;
         $display("FAIL tie_store_sw flags=%b addr=%h wstrb=%b wdata=%h required 01010 200 1111 12345678", flags, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata);
      end
      @(negedge i_clk);
      bus.st_req = 1'b0;
      #1;
      checks++;
      if (flags !== 5'b00011 || bus.mem_addr !== 32'h100) begin
         failures++;
         $display("FAIL tie_load_second flags=%b addr=%h required 00011 100", flags, bus.mem_addr);
      end
      @(negedge i_clk);
      #1;
      checks++;
      if (flags !== 5'b10001 || bus.ld_rdata !== 32'hABADBEEF) begin
         failures++;
         $display("FAIL tie_load2_done flags=%b rdata=%h required 10001 abadbeef", flags, bus.ld_rdata);
      end
      @(negedge i_clk);
      bus.ld_req = 1'b0;
      #1;
      checks++;
      if (mem[128] !== 32'h12345678) begin
         failures++;
         $display("FAIL tie_sw_mem mem=%h required 12345678", mem[128]);
      end
   endtask
   task automatic test_misaligned();
      logic [31:0] t_addr [4] = '{32'h101, 32'h100, 32'h202, 32'h102};
      logic [1:0]  t_size [4] = '{ST_SH, 2'b11, ST_SW, ST_SH};
      logic [31:0] t_data [4] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h0, 32'h00001234};
      logic [4:0]  t_flag [4] = '{5'b01101, 5'b01101, 5'b01101, 5'b01000};
      logic [3:0]  t_strb [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1100};
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         bus.st_req = 1'b1; bus.st_addr = t_addr[i]; bus.st_size = t_size[i]; bus.st_data = t_data[i];
         #1;
         checks++;
         if (flags !== t_flag[i] || bus.mem_wstrb !== t_strb[i]) begin
            failures++;
            $display("FAIL align_%0d flags=%b wstrb=%b required %b %b", i, flags, bus.mem_wstrb, t_flag[i], t_strb[i]);
         end
         @(negedge i_clk);
         bus.st_req = 1'b0;
      end
      #1;
      checks++;
      if (mem[64] !== 32'h1234BEEF || mem[128] !== 32'h12345678) begin
         failures++;
         $display("FAIL align_mem mem64=%h mem128=%h required 1234beef 12345678", mem[64], mem[128]);
      end
   endtask
   task automatic test_reset_rdwait();
      @(negedge i_clk);
      bus.ld_req = 1'b1; bus.ld_addr = 32'h200;
      #1;
      checks++;
      if (flags !== 5'b00011 || bus.mem_addr !== 32'h200) begin
         failures++;
         $display("FAIL rst_grant flags=%b addr=%h required 00011 200", flags, bus.mem_addr);
      end
      @(posedge i_clk);
      #2;
      i_rst = 1'b0; bus.ld_req = 1'b0;
      #1;
      checks++;
      if (flags !== 5'b00001 || bus.mem_addr !== 32'h0 || bus.mem_wstrb !== 4'h0 || bus.ld_rdata !== 32'h0) begin
         failures++;
         $display("FAIL rst_async flags=%b addr=%h wstrb=%b rdata=%h required 00001 0 0 0", flags, bus.mem_addr, bus.mem_wstrb, bus.ld_rdata);
      end
      @(negedge i_clk);
      #1;
      checks++;
      if (flags !== 5'b00001) begin
         failures++;
         $display("FAIL rst_no_done flags=%b required 00001", flags);
      end
      @(negedge i_clk);
      i_rst = 1'b1; bus.ld_req = 1'b1; bus.ld_addr = 32'h200;
      #1;
      checks++;
      if (flags !== 5'b00011 || bus.mem_addr !== 32'h200) begin
         failures++;
         $display("FAIL rst_regrant flags=%b addr=%h required 00011 200", flags, bus.mem_addr);
      end
      @(negedge i_clk);
      #1;
      checks++;
      if (flags !== 5'b10001 || bus.ld_rdata !== 32'h12345678) begin
         failures++;
         $display("FAIL rst_reload flags=%b rdata=%h required 10001 12345678", flags, bus.ld_rdata);
      end
      @(negedge i_clk);
      bus.ld_req = 1'b0;
   endtask
   task automatic test_back_to_back();
      logic [6:0]  exp_ld = 7'b1010010;
      logic [6:0]  exp_st = 7'b0000100;
      logic [31:0] exp_rd;
      bus.st_addr = 32'h100; bus.st_size = ST_SB; bus.st_data = 32'h00000011;
      for (int c = 0; c < 7; c++) begin
         @(negedge i_clk);
         bus.ld_req = 1'b1; bus.ld_addr = 32'h100;
         bus.st_req = (c == 1 || c == 2);
         #1;
         checks++;
         if ({bus.ld_done, bus.st_done} !== {exp_ld[c], exp_st[c]}) begin
            failures++;
            $display("FAIL stream_c%0d ld_done,st_done=%b%b required %b%b", c, bus.ld_done, bus.st_done, exp_ld[c], exp_st[c]);
         end
         exp_rd = (c == 1) ? 32'h1234BEEF : 32'h1234BE11;
         if (exp_ld[c]) begin
            checks++;
            if (bus.ld_rdata !== exp_rd) begin
               failures++;
               $display("FAIL stream_rdata_c%0d rdata=%h required %h", c, bus.ld_rdata, exp_rd);
            end
         end
      end
      @(negedge i_clk);
      bus.ld_req = 1'b0;
      #1;
      checks++;
      if (mem[64] !== 32'h1234BE11 || flags !== 5'b00001) begin
         failures++;
         $display("FAIL stream_end mem=%h flags=%b required 1234be11 00001", mem[64], flags);
      end
   endtask
   initial begin
      checks = 0; failures = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[64] = 32'hDEADBEEF;
      bus.ld_req = 1'b0; bus.ld_addr = '0;
      bus.st_req = 1'b0; bus.st_addr = '0; bus.st_size = ST_SB; bus.st_data = '0;
      test_reset();
      test_lone_load();
      test_lone_sb();
      test_tie();
      test_misaligned();
      test_reset_rdwait();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
